// File: rtl/vector_wb_buffer_pkg.sv
// Shared types for the vector ALU writeback buffer.
// Lane-count dependent entry layout lives in the top, since it needs THREADS.
package vector_wb_buffer_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } wb_state_t;

endpackage

// File: rtl/vector_wb_buffer_lane_select.sv
// Picks the lowest-indexed up-to-WPORTS active lanes of a pending mask, in
// ascending order, and returns the mask with those lanes cleared.
module vector_wb_buffer_lane_select #(
   parameter int THREADS = 4,
   parameter int WPORTS  = 2,
   parameter int TIDW    = $clog2(THREADS)
) (
   input  logic [THREADS-1:0]     pending,
   output logic [WPORTS-1:0]      sel_vld,
   output logic [WPORTS*TIDW-1:0] sel_idx,
   output logic [THREADS-1:0]     pending_nx
);

   logic [THREADS-1:0] remaining;
   logic               found;

   always_comb begin
      remaining = pending;
      found     = 1'b0;
      sel_vld   = '0;
      sel_idx   = '0;
      for (int k = 0; k < WPORTS; k++) begin
         found = 1'b0;
         for (int t = 0; t < THREADS; t++) begin
            if (!found && remaining[t]) begin
               found                    = 1'b1;
               sel_vld[k]               = 1'b1;
               sel_idx[k*TIDW +: TIDW]  = TIDW'(t);
               remaining[t]             = 1'b0;
            end
         end
      end
      pending_nx = remaining;
   end

endmodule

// File: rtl/vector_wb_buffer.sv
// Buffers vector ALU result sets and drains their active lanes into the
// register file, WPORTS lanes per cycle, strictly in arrival order.
//
// state | meaning
// IDLE  | FIFO empty, nothing to write; loads head mask once an entry lands
// DRAIN | writing out lanes of the head entry from the pending mask
module vector_wb_buffer
   import vector_wb_buffer_pkg::*;
#(
   parameter int THREADS = 4,
   parameter int DEPTH   = 2,
   parameter int WPORTS  = 2
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [4:0]                         in_rd,
   input  logic [THREADS-1:0]                 in_mask,
   input  logic [THREADS*32-1:0]              in_out,
   input  logic [THREADS*3-1:0]               in_nzo,
   input  logic                               rf_stall,
   output logic [WPORTS-1:0]                  wb_en,
   output logic [WPORTS*$clog2(THREADS)-1:0]  wb_tid,
   output logic [4:0]                         wb_rd,
   output logic [WPORTS*32-1:0]               wb_data,
   output logic [WPORTS*3-1:0]                wb_nzo,
   output logic                               busy
);

   localparam int TIDW = $clog2(THREADS);
   localparam int PTRW = $clog2(DEPTH);
   localparam int CNTW = PTRW + 1;

   typedef struct packed {
      regbits_t                  rd;
      logic [THREADS-1:0]        mask;
      word_t [THREADS-1:0]       out;
      logic [THREADS-1:0][2:0]   nzo;
   } wb_entry_t;

   wb_entry_t          mem [DEPTH];
   wb_entry_t          head;
   wb_entry_t          push_entry;
   logic [PTRW-1:0]    wr_ptr, rd_ptr;
   logic [CNTW-1:0]    count, count_nx, count_after_pop;
   wb_state_t          state, state_nx;
   logic [THREADS-1:0] pending, pending_nx, next_head_mask, sel_remaining;
   logic               push, pop;

   logic [WPORTS-1:0]      sel_vld;
   logic [WPORTS*TIDW-1:0] sel_idx;

   logic [WPORTS-1:0]      wb_en_nx;
   logic [WPORTS*TIDW-1:0] wb_tid_nx;
   logic [4:0]             wb_rd_nx;
   logic [WPORTS*32-1:0]   wb_data_nx;
   logic [WPORTS*3-1:0]    wb_nzo_nx;

   assign in_ready        = (count < CNTW'(DEPTH));
   assign push            = in_valid && in_ready;
   assign head            = mem[rd_ptr];
   assign count_after_pop = count - CNTW'(1) + CNTW'(push);
   assign busy            = (count != '0) || (state == DRAIN);

   // When the only stored entry retires, a same-cycle push is the next head.
   assign next_head_mask  = (count > CNTW'(1)) ? mem[rd_ptr + PTRW'(1)].mask : in_mask;

   always_comb begin
      push_entry.rd   = in_rd;
      push_entry.mask = in_mask;
      push_entry.out  = in_out;
      push_entry.nzo  = in_nzo;
   end

   vector_wb_buffer_lane_select #(
      .THREADS (THREADS),
      .WPORTS  (WPORTS),
      .TIDW    (TIDW)
   ) u_lane_select (
      .pending    (pending),
      .sel_vld    (sel_vld),
      .sel_idx    (sel_idx),
      .pending_nx (sel_remaining)
   );

   always_comb begin
      state_nx   = state;
      pending_nx = pending;
      pop        = 1'b0;
      wb_en_nx   = '0;
      wb_tid_nx  = '0;
      wb_rd_nx   = '0;
      wb_data_nx = '0;
      wb_nzo_nx  = '0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pending_nx = head.mask;
               state_nx   = DRAIN;
            end
         end
         DRAIN: begin
            if (!rf_stall) begin
               for (int k = 0; k < WPORTS; k++) begin
                  if (sel_vld[k]) begin
                     wb_en_nx[k]                = 1'b1;
                     wb_tid_nx[k*TIDW +: TIDW]  = sel_idx[k*TIDW +: TIDW];
                     wb_data_nx[k*32 +: 32]     = head.out[sel_idx[k*TIDW +: TIDW]];
                     wb_nzo_nx[k*3 +: 3]        = head.nzo[sel_idx[k*TIDW +: TIDW]];
                  end
               end
               if (sel_vld != '0) begin
                  wb_rd_nx = head.rd;
               end
               pending_nx = sel_remaining;
               if (sel_remaining == '0) begin
                  pop = 1'b1;
                  if (count_after_pop != '0) begin
                     pending_nx = next_head_mask;
                  end else begin
                     state_nx = IDLE;
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase
      count_nx = count + CNTW'(push) - CNTW'(pop);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         count   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         pending <= '0;
         wb_en   <= '0;
         wb_tid  <= '0;
         wb_rd   <= '0;
         wb_data <= '0;
         wb_nzo  <= '0;
      end else begin
         state   <= state_nx;
         count   <= count_nx;
         pending <= pending_nx;
         wb_en   <= wb_en_nx;
         wb_tid  <= wb_tid_nx;
         wb_rd   <= wb_rd_nx;
         wb_data <= wb_data_nx;
         wb_nzo  <= wb_nzo_nx;
         if (push) begin
            wr_ptr <= wr_ptr + PTRW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTRW'(1);
         end
      end
   end

   // Payload storage needs no reset; count and pointers qualify it.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

endmodule

// File: tb/tb_vector_wb_buffer.sv
// Scoreboard bench for vector_wb_buffer: expected write beats are queued at
// push time and compared against each cycle that carries register writes.
module tb_vector_wb_buffer;

   logic          CLK = 1'b0;
   logic          RST;
   logic          in_valid;
   logic          in_ready;
   logic [4:0]    in_rd;
   logic [3:0]    in_mask;
   logic [127:0]  in_out;
   logic [11:0]   in_nzo;
   logic          rf_stall;
   logic [1:0]    wb_en;
   logic [3:0]    wb_tid;
   logic [4:0]    wb_rd;
   logic [63:0]   wb_data;
   logic [5:0]    wb_nzo;
   logic          busy;

   logic stall_force = 1'b0;
   logic rand_en     = 1'b0;
   logic rand_bit    = 1'b0;
   assign rf_stall = stall_force | (rand_en & rand_bit);

   vector_wb_buffer #(.THREADS(4), .DEPTH(2), .WPORTS(2)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_rd    (in_rd),
      .in_mask  (in_mask),
      .in_out   (in_out),
      .in_nzo   (in_nzo),
      .rf_stall (rf_stall),
      .wb_en    (wb_en),
      .wb_tid   (wb_tid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .wb_nzo   (wb_nzo),
      .busy     (busy)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [1:0]  en;
      logic [3:0]  tid;
      logic [4:0]  rd;
      logic [63:0] data;
      logic [5:0]  nzo;
   } beat_t;

   beat_t sb [$];
   beat_t exp_beat;
   int    beat_cyc [$];
   int    cyc = 0;
   int    checks = 0;
   int    failures = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   always @(posedge CLK) cyc <= cyc + 1;
   always @(negedge CLK) rand_bit <= 1'($urandom_range(0, 1));

   always @(negedge CLK) begin
      if (!RST && wb_en != 2'b00) begin
         beat_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            check("unexpected_wb", {126'd0, wb_en}, 128'd0);
         end else begin
            exp_beat = sb.pop_front();
            check("wb_en",   {126'd0, wb_en},   {126'd0, exp_beat.en});
            check("wb_tid",  {124'd0, wb_tid},  {124'd0, exp_beat.tid});
            check("wb_rd",   {123'd0, wb_rd},   {123'd0, exp_beat.rd});
            check("wb_data", {64'd0, wb_data},  {64'd0, exp_beat.data});
            check("wb_nzo",  {122'd0, wb_nzo},  {122'd0, exp_beat.nzo});
         end
      end
   end

   // Reference: active lanes ascending, packed two per write cycle.
   task automatic model_entry(input logic [4:0] rd, input logic [3:0] mask,
                              input logic [127:0] out, input logic [11:0] nzo);
      beat_t b;
      int    p;
      b = '0;
      p = 0;
      for (int t = 0; t < 4; t++) begin
         if (mask[t]) begin
            b.en[p]          = 1'b1;
            b.tid[p*2 +: 2]  = 2'(t);
            b.data[p*32 +: 32] = out[t*32 +: 32];
            b.nzo[p*3 +: 3]  = nzo[t*3 +: 3];
            b.rd             = rd;
            p++;
            if (p == 2) begin
               sb.push_back(b);
               b = '0;
               p = 0;
            end
         end
      end
      if (p != 0) sb.push_back(b);
   endtask

   // Entered just after a falling edge; returns just after the falling edge
   // that follows the accepting rising edge.
   task automatic push(input logic [4:0] rd, input logic [3:0] mask,
                       input logic [127:0] out, input logic [11:0] nzo);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_rd    = rd;
      in_mask  = mask;
      in_out   = out;
      in_nzo   = nzo;
      while (!in_ready && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 50) check("push_timeout", 128'(n), 128'd0);
      model_entry(rd, mask, out, nzo);
      @(posedge CLK);
      @(negedge CLK);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      @(negedge CLK);
      while ((busy || wb_en != 2'b00 || sb.size() != 0) && n < max) begin
         @(negedge CLK);
         n++;
      end
      check("idle_reached", 128'(n < max), 128'd1);
   endtask

   initial begin
      int k;
      int b0;
      RST      = 1'b1;
      in_valid = 1'b0;
      in_rd    = '0;
      in_mask  = '0;
      in_out   = '0;
      in_nzo   = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_wb_en",    128'(wb_en),    128'd0);
      check("rst_wb_tid",   128'(wb_tid),   128'd0);
      check("rst_wb_rd",    128'(wb_rd),    128'd0);
      check("rst_wb_data",  128'(wb_data),  128'd0);
      check("rst_wb_nzo",   128'(wb_nzo),   128'd0);
      check("rst_busy",     128'(busy),     128'd0);
      check("rst_in_ready", 128'(in_ready), 128'd1);
      RST = 1'b0;
      @(negedge CLK);

      // full mask: latency, two beats, then quiet
      push(5'd7, 4'b1111, {32'd40, 32'd30, 32'd20, 32'd10}, 12'h000);
      k = 0;
      while (wb_en == 2'b00 && k < 10) begin
         @(negedge CLK);
         k++;
      end
      check("latency", 128'(k), 128'd2);
      @(negedge CLK);
      check("full_second_en", 128'(wb_en), 128'd3);
      @(negedge CLK);
      check("full_busy_drop", 128'(busy), 128'd0);
      check("full_done_en", 128'(wb_en), 128'd0);
      check("full_sb_empty", 128'(sb.size()), 128'd0);

      // sparse masks
      push(5'd2, 4'b1010, {32'hd4, 32'hc3, 32'hb2, 32'ha1}, 12'h000);
      wait_idle(30);
      push(5'd3, 4'b0100, {32'h4, 32'h3, 32'h2, 32'h1}, 12'hfff);
      wait_idle(30);
      b0 = beat_cyc.size();
      push(5'd4, 4'b0000, {32'h9, 32'h9, 32'h9, 32'h9}, 12'h000);
      check("zero_busy", 128'(busy), 128'd1);
      wait_idle(30);
      check("zero_no_writes", 128'(beat_cyc.size() - b0), 128'd0);

      // back-to-back full masks
      b0 = beat_cyc.size();
      push(5'd1, 4'b1111, {32'h14, 32'h13, 32'h12, 32'h11}, 12'h001);
      push(5'd2, 4'b1111, {32'h24, 32'h23, 32'h22, 32'h21}, 12'h002);
      check("b2b_full_ready", 128'(in_ready), 128'd0);
      push(5'd3, 4'b1111, {32'h34, 32'h33, 32'h32, 32'h31}, 12'h004);
      wait_idle(40);
      check("b2b_beats", 128'(beat_cyc.size() - b0), 128'd6);
      if (beat_cyc.size() >= b0 + 6)
         check("b2b_no_bubble", 128'(beat_cyc[b0+5] - beat_cyc[b0]), 128'd5);

      // register-file stall mid-entry
      b0 = beat_cyc.size();
      push(5'd9, 4'b1111, {32'h94, 32'h93, 32'h92, 32'h91}, 12'h123);
      k = 0;
      while (wb_en == 2'b00 && k < 20) begin
         @(negedge CLK);
         k++;
      end
      stall_force = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         check("stall_en", 128'(wb_en), 128'd0);
      end
      stall_force = 1'b0;
      wait_idle(30);
      check("stall_beats", 128'(beat_cyc.size() - b0), 128'd2);

      // flags routed per port
      push(5'd5, 4'b0011, {32'd0, 32'd0, 32'd0, 32'h80000000},
           {3'b000, 3'b000, 3'b010, 3'b100});
      wait_idle(30);

      // reset while draining with two entries held
      push(5'd11, 4'b1111, {32'hb4, 32'hb3, 32'hb2, 32'hb1}, 12'h000);
      push(5'd12, 4'b1111, {32'hc4, 32'hc3, 32'hc2, 32'hc1}, 12'h000);
      @(negedge CLK);
      #1;
      RST = 1'b1;
      sb.delete();
      @(negedge CLK);
      check("mid_rst_en",    128'(wb_en),    128'd0);
      check("mid_rst_busy",  128'(busy),     128'd0);
      check("mid_rst_ready", 128'(in_ready), 128'd1);
      RST = 1'b0;
      @(negedge CLK);
      check("post_rst_en", 128'(wb_en), 128'd0);
      push(5'd13, 4'b0110, {32'hd4, 32'hd3, 32'hd2, 32'hd1}, 12'h5a5);
      wait_idle(30);

      // random entries under random stalls
      rand_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push(5'($urandom), 4'($urandom_range(0, 15)),
              {$urandom, $urandom, $urandom, $urandom}, 12'($urandom));
      end
      wait_idle(400);
      rand_en = 1'b0;
      check("final_sb_empty", 128'(sb.size()), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vector_wb_buffer.md
Name: vector_wb_buffer

Overview:
- Downstream stage of the vector ALU: captures one per-thread result set (out, nf, zf, of for all THREADS lanes) plus destination register and active-thread mask.
- Buffers results in a small FIFO and drains them into the vector register file, which has only WPORTS write ports.
- Active threads are serialized WPORTS per cycle; the ALU stalls via in_ready when the FIFO is full.

Parameters:
THREADS, 4, SIMT lanes per warp; matches vector_alu_if THREADS
DEPTH, 2, FIFO entries (power of two, >=2)
WPORTS, 2, register-file write ports per cycle (1..THREADS)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
in_valid  in  1  ALU result set valid
in_ready  out  1  buffer can accept
in_rd  in  5  destination vector register
in_mask  in  THREADS  active-thread mask, bit t = lane t
in_out  in  THREADS*32  lane results, lane t at [32t+31:32t]
in_nzo  in  THREADS*3  lane flags {nf,zf,of}, lane t at [3t+2:3t]
rf_stall  in  1  register file cannot accept writes this cycle
wb_en  out  WPORTS  per-port write enable
wb_tid  out  WPORTS*$clog2(THREADS)  lane index per port
wb_rd  out  5  destination register (shared by all ports)
wb_data  out  WPORTS*32  write data per port
wb_nzo  out  WPORTS*3  flags per port
busy  out  1  FIFO non-empty or drain in progress

Behaviour:
- Reset: FIFO count=0, pointers=0, pending=0, FSM=IDLE. Outputs: wb_en=0, wb_tid=0, wb_rd=0, wb_data=0, wb_nzo=0, busy=0, in_ready=1.
- Reset mid-drain discards all entries. No write is issued in the reset cycle or the cycle after.
- Accept: push when in_valid && in_ready. in_ready = (count < DEPTH), registered-count based. There is no full-bypass: when full, no push occurs even in a pop cycle.
- Drain outputs are registered. An entry pushed into an empty buffer at edge N produces its first writes in the cycle after edge N+1, so latency from push to first wb_en = 2 cycles.
- FSM states:
  - IDLE: count=0 → stay. count>0 → load pending=head.mask, go DRAIN.
  - DRAIN, !rf_stall: select the lowest-indexed up-to-WPORTS set bits of pending, ascending. Port k gets the k-th selected lane; unused ports have wb_en=0. Register wb_* and clear those bits. If the resulting pending==0: pop head; if count after pop >0, load the next head mask (back-to-back, no bubble), else go IDLE.
  - DRAIN, rf_stall: hold pending. Next-cycle wb_en=0. FIFO is unchanged apart from pushes.
- Zero mask entry: retires in one DRAIN cycle with no writes (wb_en=0).
- wb_rd/wb_data/wb_nzo are don't-care when the matching wb_en=0; drive 0 anyway.
- Simultaneous push and pop: count unchanged; both pointers advance modulo DEPTH.
- Ordering: entries retire strictly FIFO. All writes of entry i precede any write of entry i+1.
- busy = (count != 0) || (state == DRAIN).

Decomposition:
- cpu_types_pkg: word_t (32b) and regbits_t (5b) already exist.
- Add wb_entry_t struct {regbits_t rd; logic [THREADS-1:0] mask; word_t out[THREADS]; logic [2:0] nzo[THREADS]} and wb_state_t enum {IDLE, DRAIN}.
- One sub-module, lane_select: combinational; input pending mask, outputs up to WPORTS ascending lane indices, valids, and the cleared mask. Instantiated once.

Test Plan:
- Full mask, WPORTS=2, THREADS=4: push rd=7, out={40,30,20,10}, mask=4'b1111 → cycle+2: wb_en=2'b11, tid={1,0}, data={20,10}; cycle+3: tid={3,2}, data={40,30}; busy drops the cycle after.
- Sparse mask 4'b1010: tid={3,1} in one cycle. Mask 4'b0100: one cycle with wb_en=2'b01, tid=2. Mask 4'b0000: no writes, entry retired, busy returns 0.
- Back-to-back: three pushes on consecutive cycles with full masks → in_ready=0 on the third cycle. Writes are contiguous with no bubble between entries; order is rd 1,2,3.
- rf_stall held 3 cycles mid-entry → wb_en=0 for those cycles, pending lanes preserved, no lane written twice or skipped.
- RST asserted during DRAIN with count=2 → next cycle wb_en=0, busy=0, in_ready=1. A fresh push then drains correctly.
- Flags: out={0x80000000,0,…} with nzo lane0=3'b100, lane1=3'b010 → wb_nzo matches per port/tid.
